// File: rtl/wiggle_sequencer_if.sv
// Control and pattern-output bundle for wiggle_sequencer.
// The master drives run control; the slave (the sequencer) drives the pattern and status.
interface wiggle_sequencer_if #(
    parameter int WIDTH = 14,
    parameter int DIV_W = 8
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [7:0]       ja;
    logic [7:0]       jb;
    logic             led;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, mode, div,
        input  ja, jb, led, busy, done
    );

    modport slave (
        input  start, stop, mode, div,
        output ja, jb, led, busy, done
    );
endinterface

// File: rtl/wiggle_sequencer.sv
// Pattern sequencer: drives binary, walking-one, Gray or toggle-all patterns onto
// ja/jb at a programmable tick rate, for a fixed number of ticks per run.
module wiggle_sequencer #(
    parameter int WIDTH = 14,
    parameter int DIV_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    wiggle_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_BIN    = 2'b00;
    localparam logic [1:0] MODE_WALK   = 2'b01;
    localparam logic [1:0] MODE_GRAY   = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    // Step counter compares against limit-1 so the full 2^WIDTH count fits in WIDTH bits.
    localparam logic [WIDTH-1:0] LAST_BIN    = '1;
    localparam logic [WIDTH-1:0] LAST_WALK   = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0] LAST_TOGGLE = WIDTH'(255);

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] presc_q;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] pat_q;
    logic             led_q;
    logic             busy_q;
    logic             done_q;

    logic             tick_d;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] pat_d;
    logic [WIDTH-1:0] last_d;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        tick_d = (presc_q == div_q);
        bin_d  = bin_q + 1'b1;
        pat_d  = pat_q;
        last_d = LAST_BIN;
        case (mode_q)
            MODE_BIN: begin
                pat_d  = bin_d;
                last_d = LAST_BIN;
            end
            MODE_WALK: begin
                pat_d  = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
                last_d = LAST_WALK;
            end
            MODE_GRAY: begin
                pat_d  = bin_d ^ (bin_d >> 1);
                last_d = LAST_BIN;
            end
            MODE_TOGGLE: begin
                pat_d  = ~pat_q;
                last_d = LAST_TOGGLE;
            end
            default: begin
                pat_d  = pat_q;
                last_d = LAST_BIN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_BIN;
            div_q   <= '0;
            presc_q <= '0;
            step_q  <= '0;
            bin_q   <= '0;
            pat_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_q <= RUN;
                        mode_q  <= bus.mode;
                        div_q   <= bus.div;
                        presc_q <= '0;
                        step_q  <= '0;
                        bin_q   <= '0;
                        pat_q   <= (bus.mode == MODE_WALK) ? WIDTH'(1) : '0;
                        led_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        pat_q   <= '0;
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (tick_d) begin
                        presc_q <= '0;
                        step_q  <= step_q + 1'b1;
                        bin_q   <= bin_d;
                        pat_q   <= pat_d;
                        if (step_q == last_d) begin
                            state_q <= DONE;
                            led_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ja   = pat_q[7:0];
    assign bus.jb   = {{(16 - WIDTH){1'b0}}, pat_q[WIDTH-1:8]};
    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_wiggle_sequencer.sv
// Directed bench for wiggle_sequencer: a per-clock vector table for short runs
// plus hand-written sequences for full-length runs, stop/start corners and async reset.
module tb_wiggle_sequencer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    wiggle_sequencer_if #(.WIDTH(14), .DIV_W(8)) bus ();

    wiggle_sequencer #(.WIDTH(14), .DIV_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic [1:0]  mode;
        logic [7:0]  div;
        logic [13:0] pat;
        logic        led;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] pat();
        return {bus.jb[5:0], bus.ja};
    endfunction

    task automatic check_flags(input string name, input logic led, input logic busy, input logic done);
        check({name, ".led"},  {31'd0, bus.led},  {31'd0, led});
        check({name, ".busy"}, {31'd0, bus.busy}, {31'd0, busy});
        check({name, ".done"}, {31'd0, bus.done}, {31'd0, done});
    endtask

    task automatic drive(input logic start, input logic stop, input logic [1:0] mode, input logic [7:0] div);
        bus.start = start;
        bus.stop  = stop;
        bus.mode  = mode;
        bus.div   = div;
    endtask

    initial begin
        int count;
        n_cmp = 0;
        n_err = 0;

        //            start stop mode   div   pat      led busy done
        tbl[0]  = '{1'b1, 1'b1, 2'd0, 8'd0, 14'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 8'd0, 14'h0000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'd2, 8'd0, 14'h0000, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'd3, 8'd5, 14'h0001, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 2'd3, 8'd5, 14'h0003, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'd1, 8'd9, 14'h0002, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 2'd2, 8'd0, 14'h0006, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'd2, 8'd0, 14'h0000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 8'd0, 14'h0000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 2'd0, 8'd0, 14'h0000, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 8'd0, 14'h0001, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 8'd0, 14'h0002, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 8'd0, 14'h0003, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 8'd0, 14'h0004, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 2'd0, 8'd0, 14'h0005, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 2'd0, 8'd0, 14'h0000, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 2'd0, 8'd0, 14'h0000, 1'b0, 1'b0, 1'b0};

        // Power-on reset for 10 ns, outputs checked while it is held.
        drive(1'b0, 1'b0, 2'd0, 8'd0);
        reset = 1'b1;
        #6;
        check("rst.pat", {18'd0, pat()}, 32'h0);
        check("rst.jb", {24'd0, bus.jb}, 32'h0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        #4;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("idle.pat", {18'd0, pat()}, 32'h0);
            check_flags("idle", 1'b0, 1'b0, 1'b0);
        end

        // Table: start+stop in IDLE, Gray run with ignored mode/div/start changes, stops.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].start, tbl[i].stop, tbl[i].mode, tbl[i].div);
            cyc();
            check($sformatf("tbl%0d.pat", i), {18'd0, pat()}, {18'd0, tbl[i].pat});
            check_flags($sformatf("tbl%0d", i), tbl[i].led, tbl[i].busy, tbl[i].done);
        end

        // Walking one, div=2: one step every 3 clocks, 14 ticks, ends on 0x0001.
        drive(1'b1, 1'b0, 2'd1, 8'd2);
        cyc();
        drive(1'b0, 1'b0, 2'd0, 8'd0);
        check("walk.entry", {18'd0, pat()}, 32'h1);
        for (int k = 1; k < 14; k++) begin
            cyc();
            if (k == 1) check("walk.hold1", {18'd0, pat()}, 32'h1);
            cyc();
            if (k == 1) check("walk.hold2", {18'd0, pat()}, 32'h1);
            cyc();
            check($sformatf("walk.step%0d", k), {18'd0, pat()}, 32'h1 << k);
        end
        cyc();
        cyc();
        cyc();
        check("walk.final", {18'd0, pat()}, 32'h1);
        check_flags("walk.done", 1'b0, 1'b1, 1'b1);
        check("walk.jb_hi", {30'd0, bus.jb[7:6]}, 32'h0);
        bus.start = 1'b1;  // start in DONE is ignored
        cyc();
        check_flags("walk.after", 1'b0, 1'b0, 1'b0);
        check("walk.idle_hold", {18'd0, pat()}, 32'h1);
        bus.stop = 1'b1;   // start+stop in IDLE: stays IDLE, pattern kept
        cyc();
        check_flags("walk.startstop", 1'b0, 1'b0, 1'b0);
        check("walk.startstop.pat", {18'd0, pat()}, 32'h1);
        drive(1'b0, 1'b0, 2'd0, 8'd0);
        cyc();

        // Binary count, div=0: full 16384-tick run.
        drive(1'b1, 1'b0, 2'd0, 8'd0);
        cyc();
        bus.start = 1'b0;
        count = 0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            count++;
            check($sformatf("bin.ja%0d", i), {24'd0, bus.ja}, i);
        end
        while (!bus.done && count < 20000) begin
            cyc();
            count++;
        end
        check("bin.done_latency", count, 16384);
        check("bin.final", {18'd0, pat()}, 32'h0);
        check_flags("bin.done", 1'b0, 1'b1, 1'b1);
        cyc();
        check_flags("bin.after", 1'b0, 1'b0, 1'b0);

        // Toggle-all, div=0: 256 ticks.
        drive(1'b1, 1'b0, 2'd3, 8'd0);
        cyc();
        bus.start = 1'b0;
        cyc();
        check("tog.t1", {18'd0, pat()}, 32'h3FFF);
        cyc();
        check("tog.t2", {18'd0, pat()}, 32'h0);
        count = 2;
        while (!bus.done && count < 1000) begin
            cyc();
            count++;
        end
        check("tog.done_latency", count, 256);
        check("tog.final", {18'd0, pat()}, 32'h0);
        cyc();

        // Binary count, div=3, async reset mid-period during RUN.
        drive(1'b1, 1'b0, 2'd0, 8'd3);
        cyc();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check("rstrun.before", {18'd0, pat()}, 32'h2);
        #3;
        reset = 1'b1;
        #1;
        check("rstrun.async.pat", {18'd0, pat()}, 32'h0);
        check_flags("rstrun.async", 1'b0, 1'b0, 1'b0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_flags("rstrun.idle", 1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 2'd0, 8'd3);
        cyc();
        bus.start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check("rstrun.restart.hold", {18'd0, pat()}, 32'h0);
        end
        cyc();
        check("rstrun.restart.tick", {18'd0, pat()}, 32'h1);
        check_flags("rstrun.restart", 1'b1, 1'b1, 1'b0);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        check("rstrun.stop.pat", {18'd0, pat()}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
